fmesh_local_inject_arb: RTL and testbench

- Shares one fmesh router local input port among NR endpoint requesters, e.g. the local-port endpoints of one tile.
- Arbitrates packet by packet using a round-robin pointer.
- Once a requester is granted on its header flit, it keeps the port until its tail flit is accepted.
- Tracks downstream buffer credits so it never overruns the router input buffer. Output is registered with one-cycle latency.

---
 rtl/fmesh_local_inject_arb.sv | 122 ++++++++++++
 tb/tb_fmesh_local_inject_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmesh_local_inject_arb.sv
// Local-port injection arbiter for an fmesh router: shares one router input among NR
// endpoints, packet-granular round-robin, credit-tracked, with a registered output stage.
module fmesh_local_inject_arb #(
  parameter int NR  = 4,
  parameter int Fw  = 32,
  parameter int B   = 4,
  parameter int NRw = (NR <= 1) ? 1 : $clog2(NR),
  parameter int Cw  = ((B + 1) <= 1) ? 1 : $clog2(B + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NR-1:0]    i_flit_wr,
  input  logic [NR-1:0]    i_flit_hdr,
  input  logic [NR-1:0]    i_flit_tail,
  input  logic [NR*Fw-1:0] i_flit_data,
  output logic [NR-1:0]    o_flit_ready,
  output logic [Fw-1:0]    o_flit_out,
  output logic             o_flit_out_wr,
  output logic             o_flit_out_hdr,
  output logic             o_flit_out_tail,
  input  logic             i_credit_in,
  output logic [NRw-1:0]   o_owner,
  output logic             o_locked,
  output logic             o_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         r_state, w_nextState;
  logic [NRw-1:0] r_rrPtr, r_owner;
  logic [Cw-1:0]  r_credit;
  logic           r_err;

  logic [NR-1:0]  w_hdrReq;
  logic [NRw:0]   w_idx;
  logic [NRw-1:0] w_cand, w_sel, w_selNext;
  logic           w_candFound, w_credOk, w_grantOk, w_accept;
  logic           w_selHdr, w_selTail, w_errEvent;
  logic [Fw-1:0]  w_selData;

  assign w_hdrReq = i_flit_wr & i_flit_hdr;

  // Round-robin search for a header offer, starting at the pointer and wrapping.
  always_comb begin
    w_candFound = 1'b0;
    w_cand      = '0;
    w_idx       = '0;
    for (int k = 0; k < NR; k++) begin
      w_idx = {1'b0, r_rrPtr} + (NRw+1)'(k);
      if (w_idx >= (NRw+1)'(NR)) w_idx = w_idx - (NRw+1)'(NR);
      if (!w_candFound && w_hdrReq[w_idx[NRw-1:0]]) begin
        w_candFound = 1'b1;
        w_cand      = w_idx[NRw-1:0];
      end
    end
  end

  assign w_sel     = (r_state == LOCKED) ? r_owner : w_cand;
  assign w_selNext = (w_sel == NRw'(NR - 1)) ? '0 : w_sel + 1'b1;
  assign w_credOk  = (r_credit != '0);
  assign w_grantOk = w_credOk && ((r_state == LOCKED) || w_candFound);
  assign w_accept  = w_grantOk && i_flit_wr[w_sel];
  assign w_selHdr  = i_flit_hdr[w_sel];
  assign w_selTail = i_flit_tail[w_sel];
  assign w_selData = i_flit_data[w_sel*Fw +: Fw];

  always_comb begin
    o_flit_ready = '0;
    if (w_grantOk) o_flit_ready[w_sel] = 1'b1;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && !w_selTail) w_nextState = LOCKED;
      LOCKED:  if (w_accept && w_selTail)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Body flits in IDLE, headers inside a packet and credit overflow all latch the error flag.
  assign w_errEvent = ((r_state == IDLE) && |(i_flit_wr & ~i_flit_hdr))
                   || ((r_state == LOCKED) && w_accept && w_selHdr)
                   || (i_credit_in && !w_accept && (r_credit == Cw'(B)));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rrPtr         <= '0;
      r_owner         <= '0;
      r_credit        <= Cw'(B);
      r_err           <= 1'b0;
      o_flit_out      <= '0;
      o_flit_out_wr   <= 1'b0;
      o_flit_out_hdr  <= 1'b0;
      o_flit_out_tail <= 1'b0;
    end else begin
      o_flit_out_wr <= w_accept;
      if (w_accept) begin
        o_flit_out      <= w_selData;
        o_flit_out_hdr  <= w_selHdr;
        o_flit_out_tail <= w_selTail;
      end
      if ((r_state == IDLE) && w_accept && !w_selTail) r_owner <= w_sel;
      if (w_accept && w_selTail) r_rrPtr <= w_selNext;
      if (w_accept && !i_credit_in)
        r_credit <= r_credit - 1'b1;
      else if (!w_accept && i_credit_in && (r_credit != Cw'(B)))
        r_credit <= r_credit + 1'b1;
      if (w_errEvent) r_err <= 1'b1;
    end
  end

  assign o_owner  = r_owner;
  assign o_locked = (r_state == LOCKED);
  assign o_err    = r_err;

endmodule

// File: tb/tb_fmesh_local_inject_arb.sv
// Directed bench for fmesh_local_inject_arb: packet locking, round-robin order,
// credit exhaustion, error flags and mid-packet reset.
module tb_fmesh_local_inject_arb;
  localparam int NR = 4;
  localparam int Fw = 32;
  localparam int B  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    wr, hdr, tail, ready;
  logic [NR*Fw-1:0] data;
  logic [Fw-1:0]    flitOut;
  logic             outWr, outHdr, outTail, creditIn, locked, err;
  logic [1:0]       owner;

  int vectors = 0;
  int miscompares = 0;

  fmesh_local_inject_arb #(.NR(NR), .Fw(Fw), .B(B)) dut (
    .i_clk(clk), .i_reset(reset), .i_flit_wr(wr), .i_flit_hdr(hdr), .i_flit_tail(tail),
    .i_flit_data(data), .o_flit_ready(ready), .o_flit_out(flitOut), .o_flit_out_wr(outWr),
    .o_flit_out_hdr(outHdr), .o_flit_out_tail(outTail), .i_credit_in(creditIn),
    .o_owner(owner), .o_locked(locked), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearReqs;
    wr = '0; hdr = '0; tail = '0; data = '0; creditIn = 1'b0;
  endtask

  task automatic offer(input int i, input logic h, input logic t, input logic [Fw-1:0] d);
    wr[i] = 1'b1; hdr[i] = h; tail[i] = t; data[i*Fw +: Fw] = d;
  endtask

  task automatic doReset;
    reset = 1'b1;
    clearReqs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    doReset();
    #1;
    vectors++; if (outWr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_outWr: got %b expected 0", outWr); end
    vectors++; if (flitOut !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_flitOut: got %h expected 0", flitOut); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    vectors++; if (owner !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner); end
    vectors++; if (ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0000", ready); end
  endtask

  task automatic test_three_flit;
    doReset();
    offer(2, 1'b1, 1'b0, 32'hA0); #1;
    vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL tf_ready_hdr: got %b expected 0100", ready); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL tf_locked0: got %b expected 0", locked); end
    tick();
    offer(2, 1'b0, 1'b0, 32'hA1); #1;
    vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL tf_ready_body: got %b expected 0100", ready); end
    vectors++; if (outWr !== 1'b1 || flitOut !== 32'hA0 || outHdr !== 1'b1) begin miscompares++; $display("[TB] FAIL tf_out0: got wr=%b d=%h h=%b expected wr=1 d=a0 h=1", outWr, flitOut, outHdr); end
    vectors++; if (locked !== 1'b1 || owner !== 2'd2) begin miscompares++; $display("[TB] FAIL tf_lock: got locked=%b owner=%0d expected 1/2", locked, owner); end
    tick();
    offer(2, 1'b0, 1'b1, 32'hA2); #1;
    vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL tf_ready_tail: got %b expected 0100", ready); end
    vectors++; if (outWr !== 1'b1 || flitOut !== 32'hA1 || outHdr !== 1'b0) begin miscompares++; $display("[TB] FAIL tf_out1: got wr=%b d=%h h=%b expected wr=1 d=a1 h=0", outWr, flitOut, outHdr); end
    tick();
    clearReqs(); #1;
    vectors++; if (outWr !== 1'b1 || flitOut !== 32'hA2 || outTail !== 1'b1) begin miscompares++; $display("[TB] FAIL tf_out2: got wr=%b d=%h t=%b expected wr=1 d=a2 t=1", outWr, flitOut, outTail); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL tf_unlock: got %b expected 0", locked); end
    tick();
    vectors++; if (outWr !== 1'b0 || flitOut !== 32'hA2) begin miscompares++; $display("[TB] FAIL tf_hold: got wr=%b d=%h expected wr=0 d=a2", outWr, flitOut); end
    // Pointer should now sit at 3, so requester 3 beats requester 0.
    offer(0, 1'b1, 1'b1, 32'h55); offer(3, 1'b1, 1'b1, 32'h66); #1;
    vectors++; if (ready !== 4'b1000) begin miscompares++; $display("[TB] FAIL tf_rrptr: got %b expected 1000", ready); end
    tick();
    vectors++; if (flitOut !== 32'h66) begin miscompares++; $display("[TB] FAIL tf_rr_data: got %h expected 66", flitOut); end
    clearReqs();
  endtask

  task automatic test_round_robin;
    logic [3:0] expReady;
    doReset();
    for (int k = 0; k < NR; k++) offer(k, 1'b1, 1'b1, 32'hB0 + k);
    creditIn = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #1;
      expReady = 4'b0001 << (s % 4);
      vectors++; if (ready !== expReady) begin miscompares++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", s, ready, expReady); end
      tick();
      vectors++; if (outWr !== 1'b1 || flitOut !== 32'hB0 + (s % 4)) begin miscompares++; $display("[TB] FAIL rr_data%0d: got wr=%b d=%h expected wr=1 d=%h", s, outWr, flitOut, 32'hB0 + (s % 4)); end
    end
    clearReqs(); #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_err: got %b expected 0", err); end
  endtask

  task automatic test_lock_stall;
    doReset();
    offer(1, 1'b1, 1'b0, 32'hC0); #1;
    vectors++; if (ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL ls_hdr: got %b expected 0010", ready); end
    tick();
    offer(1, 1'b0, 1'b0, 32'hC1); offer(0, 1'b1, 1'b1, 32'hD0); #1;
    vectors++; if (ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL ls_stall_body: got %b expected 0010", ready); end
    tick();
    offer(1, 1'b0, 1'b1, 32'hC2); #1;
    vectors++; if (ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL ls_stall_tail: got %b expected 0010", ready); end
    tick();
    wr[1] = 1'b0; hdr[1] = 1'b0; tail[1] = 1'b0; #1;
    vectors++; if (ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL ls_next_grant: got %b expected 0001", ready); end
    vectors++; if (flitOut !== 32'hC2 || locked !== 1'b0) begin miscompares++; $display("[TB] FAIL ls_tail_out: got d=%h locked=%b expected c2/0", flitOut, locked); end
    tick();
    vectors++; if (flitOut !== 32'hD0 || outHdr !== 1'b1 || outTail !== 1'b1) begin miscompares++; $display("[TB] FAIL ls_d0: got d=%h h=%b t=%b expected d0/1/1", flitOut, outHdr, outTail); end
    clearReqs();
  endtask

  task automatic test_credit_exhaust;
    doReset();
    for (int f = 0; f < 4; f++) begin
      offer(2, (f == 0), 1'b0, 32'hE0 + f); #1;
      vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL ce_accept%0d: got %b expected 0100", f, ready); end
      tick();
    end
    offer(2, 1'b0, 1'b0, 32'hE4); #1;
    vectors++; if (ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL ce_empty: got %b expected 0000", ready); end
    vectors++; if (outWr !== 1'b1 || flitOut !== 32'hE3) begin miscompares++; $display("[TB] FAIL ce_out3: got wr=%b d=%h expected 1/e3", outWr, flitOut); end
    tick();
    vectors++; if (ready !== 4'b0000 || outWr !== 1'b0 || locked !== 1'b1) begin miscompares++; $display("[TB] FAIL ce_stalled: got ready=%b wr=%b locked=%b expected 0000/0/1", ready, outWr, locked); end
    creditIn = 1'b1; #1;
    vectors++; if (ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL ce_cred_pending: got %b expected 0000", ready); end
    tick();
    creditIn = 1'b0; #1;
    vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL ce_one_credit: got %b expected 0100", ready); end
    tick();
    #1;
    vectors++; if (ready !== 4'b0000 || flitOut !== 32'hE4) begin miscompares++; $display("[TB] FAIL ce_one_only: got ready=%b d=%h expected 0000/e4", ready, flitOut); end
    creditIn = 1'b1;
    tick();
    offer(2, 1'b0, 1'b1, 32'hE5); #1;
    vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL ce_tail_ready: got %b expected 0100", ready); end
    tick();
    clearReqs();
    offer(2, 1'b1, 1'b1, 32'hF0); #1;
    vectors++; if (ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL ce_simul_keep: got %b expected 0100", ready); end
    tick();
    offer(2, 1'b1, 1'b1, 32'hF1); #1;
    vectors++; if (ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL ce_simul_drain: got %b expected 0000", ready); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL ce_err: got %b expected 0", err); end
    clearReqs();
  endtask

  task automatic test_errors;
    doReset();
    offer(1, 1'b0, 1'b0, 32'h77); #1;
    vectors++; if (ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL er_body_idle_ready: got %b expected 0000", ready); end
    tick();
    clearReqs(); #1;
    vectors++; if (err !== 1'b1 || outWr !== 1'b0) begin miscompares++; $display("[TB] FAIL er_body_idle: got err=%b wr=%b expected 1/0", err, outWr); end
    tick(); tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL er_sticky1: got %b expected 1", err); end
    doReset();
    creditIn = 1'b1;
    tick();
    creditIn = 1'b0; #1;
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL er_overflow: got %b expected 1", err); end
    tick(); tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL er_sticky2: got %b expected 1", err); end
    doReset();
    offer(0, 1'b1, 1'b0, 32'h80);
    tick();
    offer(0, 1'b1, 1'b0, 32'h81);
    tick();
    clearReqs(); #1;
    vectors++; if (err !== 1'b1 || flitOut !== 32'h81 || outHdr !== 1'b1) begin miscompares++; $display("[TB] FAIL er_hdr_locked: got err=%b d=%h h=%b expected 1/81/1", err, flitOut, outHdr); end
    doReset(); #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL er_cleared: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_packet;
    doReset();
    offer(1, 1'b1, 1'b0, 32'h90);
    tick();
    offer(1, 1'b0, 1'b0, 32'h91);
    tick();
    offer(1, 1'b0, 1'b0, 32'h92);
    reset = 1'b1;
    tick();
    vectors++; if (locked !== 1'b0 || outWr !== 1'b0 || owner !== 2'd0 || flitOut !== 32'h0) begin miscompares++; $display("[TB] FAIL rm_state: got locked=%b wr=%b owner=%0d d=%h expected 0/0/0/0", locked, outWr, owner, flitOut); end
    reset = 1'b0;
    clearReqs();
    for (int f = 0; f < 4; f++) begin
      offer(3, (f == 0), (f == 3), 32'h60 + f); #1;
      vectors++; if (ready !== 4'b1000) begin miscompares++; $display("[TB] FAIL rm_grant%0d: got %b expected 1000", f, ready); end
      tick();
      if (f == 0) begin
        vectors++; if (locked !== 1'b1 || owner !== 2'd3) begin miscompares++; $display("[TB] FAIL rm_owner: got locked=%b owner=%0d expected 1/3", locked, owner); end
      end
    end
    clearReqs(); #1;
    vectors++; if (flitOut !== 32'h63 || outTail !== 1'b1 || locked !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_tail: got d=%h t=%b locked=%b expected 63/1/0", flitOut, outTail, locked); end
  endtask

  initial begin
    reset = 1'b1;
    clearReqs();
    test_reset();
    test_three_flit();
    test_round_robin();
    test_lock_stall();
    test_credit_exhaust();
    test_errors();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
